stopwatch_ctrl: RTL

- Control block for the LED-display stopwatch.
- Debounces three raw push-buttons (start/stop, lap, clear) and runs a RUN/PAUSE/IDLE state machine.
- Sequences an internal prescaler and a 0..COUNT_MAX seconds counter.
- Drives the value to be shown by the downstream LED/7-segment driver, selecting between the live count and a frozen lap value.

---
 rtl/stopwatch_pkg.sv | 16 +
 rtl/btn_debounce.sv | 46 ++++
 rtl/stopwatch_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control block.
// State encoding, count width and default timing constants.
package stopwatch_pkg;

  localparam int CNT_W          = 8;
  localparam int TICK_DIV_DEF   = 20000000;
  localparam int COUNT_MAX_DEF  = 32;
  localparam int DEB_CYCLES_DEF = 1000000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
// Pulse appears 2 + DEB_CYCLES cycles after the raw level rises; no backpressure.
module btn_debounce
  import stopwatch_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int             CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // The pulse is issued in the same cycle the accepted level rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        pulse <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced buttons, IDLE/RUN/PAUSE FSM, prescaler, counter, lap freeze.
// Outputs registered; disp follows q/lap one cycle later; no backpressure.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int COUNT_MAX  = COUNT_MAX_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_lap,
  input  logic             btn_clr,
  output logic [CNT_W-1:0] q,
  output logic [CNT_W-1:0] disp,
  output logic             running,
  output logic             paused,
  output logic             lap_valid,
  output logic             wrap
);

  localparam int               PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] Q_MAX    = CNT_W'(COUNT_MAX);

  state_t           state;
  state_t           state_nxt;
  logic [PW-1:0]    pre;
  logic [CNT_W-1:0] lap_q;
  logic             start_p;
  logic             lap_p;
  logic             clr_p;
  logic             tick;
  logic             lap_act;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_start),
    .pulse (start_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_lap (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_lap),
    .pulse (lap_p)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_clr),
    .pulse (clr_p)
  );

  assign tick    = (state == ST_RUN) && (pre == PRE_LAST);
  // Lap yields to both clear and start/stop arriving in the same cycle.
  assign lap_act = lap_p && !start_p && !clr_p;

  always_comb begin
    state_nxt = state;
    if (clr_p) begin
      state_nxt = ST_IDLE;
    end else if (start_p) begin
      case (state)
        ST_IDLE:  state_nxt = ST_RUN;
        ST_RUN:   state_nxt = ST_PAUSE;
        ST_PAUSE: state_nxt = ST_RUN;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre       <= '0;
      q         <= '0;
      wrap      <= 1'b0;
      lap_q     <= '0;
      lap_valid <= 1'b0;
      disp      <= '0;
    end else begin
      wrap <= 1'b0;
      disp <= lap_valid ? lap_q : q;
      if (clr_p) begin
        pre       <= '0;
        q         <= '0;
        lap_q     <= '0;
        lap_valid <= 1'b0;
      end else begin
        // Prescaler holds outside RUN so a resume continues the current second.
        if (state == ST_RUN) begin
          pre <= tick ? '0 : pre + 1'b1;
        end
        if (tick) begin
          if (q < Q_MAX) begin
            q <= q + 1'b1;
          end else begin
            q    <= '0;
            wrap <= 1'b1;
          end
        end
        if (lap_act) begin
          if (state == ST_RUN && !lap_valid) begin
            lap_q     <= q;
            lap_valid <= 1'b1;
          end else if (state != ST_IDLE) begin
            lap_valid <= 1'b0;
          end
        end
      end
    end
  end

  assign running = (state == ST_RUN);
  assign paused  = (state == ST_PAUSE);

endmodule
